wb_upsizer: RTL and testbench
=============================

Name: wb_upsizer

Overview:
Parametrised Wishbone (pipelined) bus-width upsizer: a narrow DWIN-bit slave port drives a wide DWOUT-bit master port, for any power-of-two ratio. Sits between the ZipCPU data bus and the wide memory/video bus. Adds over the previous fixed 32-to-128 design: a generic ratio, selectable lane order, a depth-bounded return-lane FIFO with full-stall, clean abort/error flush, and an asynchronous active-low reset.

Parameters:
AWIN, 30, slave word-address width
DWIN, 32, slave data width (power of two, >=8)
DWOUT, 128, master data width (power of two multiple of DWIN; ratio 1 allowed)
LGFIFO, 5, log2 of maximum outstanding requests (return-lane FIFO depth)
OPT_LITTLE_ENDIAN, 0, 0: sub-word 0 occupies the MSBs; 1: sub-word 0 occupies the LSBs
Derived (localparam): R=DWOUT/DWIN, LGR=log2(R), AWOUT=AWIN-LGR

Ports:
i_clk  in  1  system clock
i_reset_n  in  1  asynchronous active-low reset
i_s_cyc, i_s_stb, i_s_we  in  1 each  slave bus cycle/strobe/write
i_s_addr  in  AWIN  slave word address
i_s_data  in  DWIN  slave write data
i_s_sel  in  DWIN/8  slave byte selects
o_s_stall  out  1  slave stall
o_s_ack  out  1  slave acknowledge
o_s_data  out  DWIN  slave read data
o_s_err  out  1  slave bus error
o_m_cyc, o_m_stb, o_m_we  out  1 each  master cycle/strobe/write
o_m_addr  out  AWOUT  master address = i_s_addr[AWIN-1:LGR]
o_m_data  out  DWOUT  master write data, DWIN word placed in lane i_s_addr[LGR-1:0]
o_m_sel  out  DWOUT/8  master selects, i_s_sel in that lane, all other bits 0
i_m_ack, i_m_stall, i_m_err  in  1 each  master ack/stall/error
i_m_data  in  DWOUT  master read data

Behaviour:
- Reset (i_reset_n low, asynchronous): all outputs 0, FIFO pointers 0, skid buffer empty. Deassertion is synchronous to i_clk by the system.
- Lane k (k=i_s_addr[LGR-1:0]): big-endian bits [DWOUT-1-k*DWIN -: DWIN]; little-endian bits [k*DWIN +: DWIN]. R=1: pass-through, lane always 0.
- Request path: registered, 1-cycle latency slave-accept to o_m_stb. One-entry skid buffer holds a request accepted while o_m_stb && i_m_stall; o_s_stall = skid full OR FIFO full (count == 2^LGFIFO). Skid drains into o_m_* the first cycle !i_m_stall; no request lost or duplicated.
- Accept = i_s_stb && !o_s_stall && i_s_cyc && !o_s_err. Each accept pushes its lane k into the return FIFO.
- o_m_cyc <= i_s_cyc && !o_s_err && !(o_m_cyc && i_m_err).
- Response: on i_m_ack with FIFO non-empty, pop lane k; next cycle o_s_ack=1, o_s_data = lane k of i_m_data. Ack latency master-to-slave = 1 cycle. Push and pop same cycle: count unchanged. Ack with FIFO empty (spurious/late): ignored, no o_s_ack.
- FIFO pointers LGFIFO+1 bits, wrap naturally; full/empty from pointer MSB compare.
- Error: i_m_err while o_m_cyc -> o_s_err=1 for exactly one cycle (next cycle), o_m_cyc/o_m_stb drop, skid and FIFO flushed; further acks ignored until new cycle. o_s_ack never asserted with o_s_err.
- Abort: i_s_cyc low -> next cycle o_m_cyc=o_m_stb=0, skid and FIFO flushed, o_s_ack=o_s_err=0. In-flight master acks after abort ignored.
- o_s_data holds last value when no ack (not required to zero).

Test Plan:
- Reset mid-transfer: 3 reads outstanding, pull i_reset_n low -> same-cycle o_m_cyc=o_m_stb=o_s_ack=0; after release, new read completes normally.
- Write lanes, DWOUT=128 big-endian: write addr 0x102, data 0xDEADBEEF, sel 0xF -> o_m_addr=0x40, o_m_data=0x0000_0000_0000_0000_DEAD_BEEF_0000_0000, o_m_sel=0x00F0; repeat OPT_LITTLE_ENDIAN=1 -> data at bits[95:64], sel 0x0F00.
- Pipelined reads addr 0..3 back-to-back, slave returns 128'h11111111_22222222_33333333_44444444 each ack -> o_s_data 0x11111111,0x22222222,0x33333333,0x44444444, each 1 cycle after i_m_ack.
- Stall/skid: i_m_stall high 5 cycles during 4-request burst -> o_s_stall asserts after one skid entry, all 4 requests issue in order, none duplicated.
- FIFO full, LGFIFO=2: 4 reads, withhold acks -> o_s_stall=1 on 5th; one ack -> 5th accepted next cycle.
- Error: i_m_err with 2 outstanding -> one-cycle o_s_err, o_m_cyc=0 next cycle, later i_m_ack produces no o_s_ack.

Source files
------------

// File: rtl/wb_upsizer.sv
// wb_upsizer: pipelined Wishbone bus-width upsizer.
// A narrow DWIN-bit slave port drives a wide DWOUT-bit master port. Each
// slave word is placed in the lane chosen by the low address bits. The lane
// of every outstanding request is queued, so the matching sub-word of the
// wide read data can be returned on the slave acknowledge.
//
// Ports
//   i_clk, i_reset_n                system clock, async active-low reset
//   i_s_cyc/stb/we/addr/data/sel    narrow slave request
//   o_s_stall/ack/data/err          narrow slave response
//   o_m_cyc/stb/we/addr/data/sel    wide master request (registered)
//   i_m_ack/stall/err/data          wide master response
//
// LGFIFO must be at least 1.
module wb_upsizer #(
  parameter int AWIN              = 30,
  parameter int DWIN              = 32,
  parameter int DWOUT             = 128,
  parameter int LGFIFO            = 5,
  parameter int OPT_LITTLE_ENDIAN = 0
) (
  input  logic                                     i_clk,
  input  logic                                     i_reset_n,
  input  logic                                     i_s_cyc,
  input  logic                                     i_s_stb,
  input  logic                                     i_s_we,
  input  logic [AWIN-1:0]                          i_s_addr,
  input  logic [DWIN-1:0]                          i_s_data,
  input  logic [DWIN/8-1:0]                        i_s_sel,
  output logic                                     o_s_stall,
  output logic                                     o_s_ack,
  output logic [DWIN-1:0]                          o_s_data,
  output logic                                     o_s_err,
  output logic                                     o_m_cyc,
  output logic                                     o_m_stb,
  output logic                                     o_m_we,
  output logic [AWIN-$clog2(DWOUT/DWIN)-1:0]       o_m_addr,
  output logic [DWOUT-1:0]                         o_m_data,
  output logic [DWOUT/8-1:0]                       o_m_sel,
  input  logic                                     i_m_ack,
  input  logic                                     i_m_stall,
  input  logic                                     i_m_err,
  input  logic [DWOUT-1:0]                         i_m_data
);

  localparam int R     = DWOUT / DWIN;
  localparam int LGR   = $clog2(R);
  localparam int AWOUT = AWIN - LGR;
  localparam int LW    = (LGR > 0) ? LGR : 1;
  localparam int SW    = DWIN / 8;
  localparam int SWOUT = DWOUT / 8;
  localparam int DEPTH = 1 << LGFIFO;

  // Bit offset of lane j inside the wide word.
  function automatic int lane_bit(input int j);
    return (OPT_LITTLE_ENDIAN != 0) ? j * DWIN : (R - 1 - j) * DWIN;
  endfunction

  logic [LW-1:0]    lane_in;
  logic [LW-1:0]    rd_lane;
  logic [DWOUT-1:0] wide_data;
  logic [SWOUT-1:0] wide_sel;
  logic [DWIN-1:0]  rd_word;

  // With a ratio of 1 there are no lane bits; everything sits in lane 0.
  generate
    if (LGR > 0) begin : g_lane
      assign lane_in = i_s_addr[LW-1:0];
    end else begin : g_no_lane
      assign lane_in = '0;
    end
  endgenerate

  always_comb begin
    wide_data = '0;
    wide_sel  = '0;
    for (int j = 0; j < R; j++) begin
      if (lane_in == LW'(j)) begin
        wide_data[lane_bit(j) +: DWIN] = i_s_data;
        wide_sel[lane_bit(j)/8 +: SW]  = i_s_sel;
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int j = 0; j < R; j++) begin
      if (rd_lane == LW'(j)) begin
        rd_word = i_m_data[lane_bit(j) +: DWIN];
      end
    end
  end

  // Return-lane FIFO, one entry per request accepted but not yet acked.
  logic [LW-1:0]   lane_mem [DEPTH];
  logic [LGFIFO:0] wr_ptr, rd_ptr;
  logic            fifo_empty, fifo_full;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[LGFIFO] != rd_ptr[LGFIFO]) &&
                      (wr_ptr[LGFIFO-1:0] == rd_ptr[LGFIFO-1:0]);
  assign rd_lane    = lane_mem[rd_ptr[LGFIFO-1:0]];

  // One-entry skid buffer, holding an already-widened request.
  logic             skid_valid;
  logic             skid_we;
  logic [AWOUT-1:0] skid_addr;
  logic [DWOUT-1:0] skid_data;
  logic [SWOUT-1:0] skid_sel;

  logic accept, bus_err, flush, ack_pop, m_free;

  assign o_s_stall = skid_valid || fifo_full;
  assign accept    = i_s_stb && i_s_cyc && !o_s_stall && !o_s_err;
  assign bus_err   = o_m_cyc && i_m_err;
  // Abort and bus error both discard everything in flight.
  assign flush     = !i_s_cyc || bus_err;
  assign ack_pop   = i_m_ack && !fifo_empty && !flush;
  // Output register can take a new request this cycle.
  assign m_free    = !o_m_stb || !i_m_stall;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_m_cyc    <= 1'b0;
      o_m_stb    <= 1'b0;
      o_m_we     <= 1'b0;
      o_m_addr   <= '0;
      o_m_data   <= '0;
      o_m_sel    <= '0;
      skid_valid <= 1'b0;
      skid_we    <= 1'b0;
      skid_addr  <= '0;
      skid_data  <= '0;
      skid_sel   <= '0;
    end else begin
      o_m_cyc <= i_s_cyc && !o_s_err && !bus_err;
      if (flush) begin
        o_m_stb    <= 1'b0;
        skid_valid <= 1'b0;
      end else if (m_free) begin
        // A full skid stalls the slave, so accept cannot coincide with it.
        if (skid_valid) begin
          o_m_stb    <= 1'b1;
          o_m_we     <= skid_we;
          o_m_addr   <= skid_addr;
          o_m_data   <= skid_data;
          o_m_sel    <= skid_sel;
          skid_valid <= 1'b0;
        end else if (accept) begin
          o_m_stb  <= 1'b1;
          o_m_we   <= i_s_we;
          o_m_addr <= i_s_addr[AWIN-1:LGR];
          o_m_data <= wide_data;
          o_m_sel  <= wide_sel;
        end else begin
          o_m_stb <= 1'b0;
        end
      end else if (accept) begin
        skid_valid <= 1'b1;
        skid_we    <= i_s_we;
        skid_addr  <= i_s_addr[AWIN-1:LGR];
        skid_data  <= wide_data;
        skid_sel   <= wide_sel;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept)  wr_ptr <= wr_ptr + (LGFIFO+1)'(1);
      if (ack_pop) rd_ptr <= rd_ptr + (LGFIFO+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept && !flush) lane_mem[wr_ptr[LGFIFO-1:0]] <= lane_in;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_s_ack  <= 1'b0;
      o_s_err  <= 1'b0;
      o_s_data <= '0;
    end else begin
      o_s_ack <= ack_pop;
      o_s_err <= i_s_cyc && bus_err;
      if (ack_pop) o_s_data <= rd_word;
    end
  end

endmodule

// File: tb/tb_wb_upsizer.sv
module tb_wb_upsizer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cyc, stb, we;
  logic [29:0]  addr;
  logic [31:0]  sdata;
  logic [3:0]   sel;
  logic         mack, mstall, merr;
  logic [127:0] mdata;

  logic         be_s_stall, be_s_ack, be_s_err, be_m_cyc, be_m_stb, be_m_we;
  logic [31:0]  be_s_data;
  logic [27:0]  be_m_addr;
  logic [127:0] be_m_data;
  logic [15:0]  be_m_sel;
  logic         le_s_stall, le_s_ack, le_s_err, le_m_cyc, le_m_stb, le_m_we;
  logic [31:0]  le_s_data;
  logic [27:0]  le_m_addr;
  logic [127:0] le_m_data;
  logic [15:0]  le_m_sel;

  always #5 clk = ~clk;

  wb_upsizer #(.LGFIFO(2), .OPT_LITTLE_ENDIAN(0)) u_be (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_s_cyc(cyc), .i_s_stb(stb), .i_s_we(we), .i_s_addr(addr),
    .i_s_data(sdata), .i_s_sel(sel),
    .o_s_stall(be_s_stall), .o_s_ack(be_s_ack), .o_s_data(be_s_data), .o_s_err(be_s_err),
    .o_m_cyc(be_m_cyc), .o_m_stb(be_m_stb), .o_m_we(be_m_we), .o_m_addr(be_m_addr),
    .o_m_data(be_m_data), .o_m_sel(be_m_sel),
    .i_m_ack(mack), .i_m_stall(mstall), .i_m_err(merr), .i_m_data(mdata)
  );

  wb_upsizer #(.LGFIFO(2), .OPT_LITTLE_ENDIAN(1)) u_le (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_s_cyc(cyc), .i_s_stb(stb), .i_s_we(we), .i_s_addr(addr),
    .i_s_data(sdata), .i_s_sel(sel),
    .o_s_stall(le_s_stall), .o_s_ack(le_s_ack), .o_s_data(le_s_data), .o_s_err(le_s_err),
    .o_m_cyc(le_m_cyc), .o_m_stb(le_m_stb), .o_m_we(le_m_we), .o_m_addr(le_m_addr),
    .o_m_data(le_m_data), .o_m_sel(le_m_sel),
    .i_m_ack(mack), .i_m_stall(mstall), .i_m_err(merr), .i_m_data(mdata)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        we;
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
  } req_t;

  typedef struct {
    logic [29:0]  addr;
    logic [31:0]  data;
    logic [3:0]   sel;
    logic [27:0]  maddr;
    logic [127:0] md_be;
    logic [15:0]  ms_be;
    logic [127:0] md_le;
    logic [15:0]  ms_le;
  } vec_t;

  // Reference model: requests awaiting issue, lanes awaiting ack.
  req_t        req_q[$];
  int          lane_q[$];
  logic        exp_ack, exp_err, exp_mcyc;
  logic [31:0] exp_sd_be, exp_sd_le;
  bit          last_acc;
  int          n_issued = 0;

  function automatic int lane_pos(input int le, input int k);
    return (le != 0) ? k * 32 : (3 - k) * 32;
  endfunction

  function automatic logic [127:0] place(input int le, input int k, input logic [31:0] d);
    return 128'(d) << lane_pos(le, k);
  endfunction

  function automatic logic [15:0] place_sel(input int le, input int k, input logic [3:0] s);
    return 16'(s) << (lane_pos(le, k) / 8);
  endfunction

  function automatic logic [31:0] pick(input int le, input int k, input logic [127:0] w);
    return 32'(w >> lane_pos(le, k));
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_clear();
    req_q.delete();
    lane_q.delete();
    exp_ack   = 1'b0;
    exp_err   = 1'b0;
    exp_mcyc  = 1'b0;
    exp_sd_be = '0;
    exp_sd_le = '0;
  endtask

  task automatic chk_out(input string t, input logic ack, input logic err, input logic mcyc,
                         input logic mstb, input logic stall, input logic [31:0] sd,
                         input logic [31:0] esd);
    check({t, " s_ack"}, ack, exp_ack);
    check({t, " s_err"}, err, exp_err);
    check({t, " m_cyc"}, mcyc, exp_mcyc);
    check({t, " m_stb"}, mstb, req_q.size() > 0);
    check({t, " s_stall"}, stall, (req_q.size() >= 2) || (lane_q.size() == 4));
    if (exp_ack) check({t, " s_data"}, sd, esd);
  endtask

  // Apply the current inputs for one clock and check against the model.
  // Called at a negedge, returns at the next negedge.
  task automatic tick();
    req_t r;
    int   k;
    bit   stall_p, acc, fl, nack;
    logic nerr, nmcyc;
    stall_p = (req_q.size() >= 2) || (lane_q.size() == 4);
    acc     = cyc && stb && !stall_p && !exp_err;
    if (req_q.size() > 0 && !mstall) begin
      r = req_q.pop_front();
      k = int'(r.addr[1:0]);
      n_issued++;
      check("be m_we", be_m_we, r.we);
      check("be m_addr", be_m_addr, r.addr[29:2]);
      check("be m_data", be_m_data, place(0, k, r.data));
      check("be m_sel", be_m_sel, place_sel(0, k, r.sel));
      check("le m_we", le_m_we, r.we);
      check("le m_addr", le_m_addr, r.addr[29:2]);
      check("le m_data", le_m_data, place(1, k, r.data));
      check("le m_sel", le_m_sel, place_sel(1, k, r.sel));
    end
    fl   = !cyc || (exp_mcyc && merr);
    nack = 1'b0;
    if (fl) begin
      req_q.delete();
      lane_q.delete();
    end else begin
      if (mack && lane_q.size() > 0) begin
        k         = lane_q.pop_front();
        nack      = 1'b1;
        exp_sd_be = pick(0, k, mdata);
        exp_sd_le = pick(1, k, mdata);
      end
      if (acc) begin
        r.we   = we;
        r.addr = addr;
        r.data = sdata;
        r.sel  = sel;
        req_q.push_back(r);
        lane_q.push_back(int'(addr[1:0]));
      end
    end
    last_acc = acc && !fl;
    nerr     = cyc && exp_mcyc && merr;
    nmcyc    = cyc && !exp_err && !(exp_mcyc && merr);
    @(posedge clk);
    exp_ack  = nack;
    exp_err  = nerr;
    exp_mcyc = nmcyc;
    @(negedge clk);
    chk_out("be", be_s_ack, be_s_err, be_m_cyc, be_m_stb, be_s_stall, be_s_data, exp_sd_be);
    chk_out("le", le_s_ack, le_s_err, le_m_cyc, le_m_stb, le_s_stall, le_s_data, exp_sd_le);
  endtask

  vec_t        vecs[4];
  logic [31:0] pr_be[4];
  logic [31:0] pr_le[4];

  initial begin
    int r;
    int iss0;

    vecs[0] = '{30'h102, 32'hDEADBEEF, 4'hF, 28'h40,
                128'h00000000_00000000_DEADBEEF_00000000, 16'h00F0,
                128'h00000000_DEADBEEF_00000000_00000000, 16'h0F00};
    vecs[1] = '{30'h3FFFFFFF, 32'h12345678, 4'h3, 28'hFFFFFFF,
                128'h00000000_00000000_00000000_12345678, 16'h0003,
                128'h12345678_00000000_00000000_00000000, 16'h3000};
    vecs[2] = '{30'h4, 32'hA5A50F0F, 4'h8, 28'h1,
                128'hA5A50F0F_00000000_00000000_00000000, 16'h8000,
                128'h00000000_00000000_00000000_A5A50F0F, 16'h0008};
    vecs[3] = '{30'h1, 32'hCAFEF00D, 4'h5, 28'h0,
                128'h00000000_CAFEF00D_00000000_00000000, 16'h0500,
                128'h00000000_00000000_CAFEF00D_00000000, 16'h0050};
    pr_be = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    pr_le = '{32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

    rst_n = 1'b0;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; sdata = '0; sel = '0;
    mack = 1'b0; mstall = 1'b0; merr = 1'b0; mdata = '0;
    model_clear();
    #3;
    check("reset m_cyc", be_m_cyc, 1'b0);
    check("reset m_stb", be_m_stb, 1'b0);
    check("reset s_ack", be_s_ack, 1'b0);
    check("reset s_err", be_s_err, 1'b0);
    check("reset s_stall", be_s_stall, 1'b0);
    check("reset m_data", be_m_data, '0);
    check("reset m_sel", be_m_sel, '0);
    check("reset le m_stb", le_m_stb, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Lane placement table.
    cyc = 1'b1;
    for (int i = 0; i < 4; i++) begin
      stb = 1'b1; we = 1'b1; addr = vecs[i].addr; sdata = vecs[i].data; sel = vecs[i].sel;
      tick();
      stb = 1'b0;
      check("vec be m_addr", be_m_addr, vecs[i].maddr);
      check("vec be m_data", be_m_data, vecs[i].md_be);
      check("vec be m_sel", be_m_sel, vecs[i].ms_be);
      check("vec le m_data", le_m_data, vecs[i].md_le);
      check("vec le m_sel", le_m_sel, vecs[i].ms_le);
      check("vec m_we", be_m_we, 1'b1);
      mack = 1'b1; mdata = {$urandom, $urandom, $urandom, $urandom};
      tick();
      mack = 1'b0;
      tick();
    end

    // Pipelined reads, lanes 0..3 returned from one wide word.
    we = 1'b0;
    for (int a = 0; a < 4; a++) begin
      stb = 1'b1; addr = 30'(a);
      tick();
    end
    stb = 1'b0;
    mdata = 128'h11111111_22222222_33333333_44444444;
    for (int j = 0; j < 4; j++) begin
      mack = 1'b1;
      tick();
      check("pipe be ack", be_s_ack, 1'b1);
      check("pipe be data", be_s_data, pr_be[j]);
      check("pipe le data", le_s_data, pr_le[j]);
    end
    mack = 1'b0;
    tick();
    check("pipe ack done", be_s_ack, 1'b0);

    // Master stall of 5 cycles during a 4-request burst.
    r = 0;
    iss0 = n_issued;
    for (int c = 0; c < 12; c++) begin
      mstall = (c < 5);
      stb    = (r < 4);
      addr   = 30'h10 + 30'(r);
      tick();
      if (last_acc) r++;
      if (c == 1) begin
        check("skid be stall", be_s_stall, 1'b1);
        check("skid le stall", le_s_stall, 1'b1);
      end
    end
    stb = 1'b0;
    check("skid accepted", r, 4);
    check("skid issued", n_issued - iss0, 4);
    mack = 1'b1;
    repeat (4) tick();
    mack = 1'b0;
    tick();

    // Return FIFO full with 4 outstanding.
    for (int a = 0; a < 4; a++) begin
      stb = 1'b1; addr = 30'h30 + 30'(a);
      tick();
    end
    addr = 30'h20;
    check("full stall", be_s_stall, 1'b1);
    tick();
    check("full held", be_m_stb, 1'b0);
    mack = 1'b1;
    tick();
    mack = 1'b0;
    check("full released", be_s_stall, 1'b0);
    tick();
    check("full 5th stb", be_m_stb, 1'b1);
    check("full 5th addr", be_m_addr, 28'h8);
    stb = 1'b0;
    mack = 1'b1;
    repeat (4) tick();
    mack = 1'b0;
    tick();

    // Bus error with two reads outstanding.
    for (int a = 0; a < 2; a++) begin
      stb = 1'b1; addr = 30'h40 + 30'(a);
      tick();
    end
    stb = 1'b0;
    merr = 1'b1;
    tick();
    merr = 1'b0;
    check("err s_err", be_s_err, 1'b1);
    check("err m_cyc", be_m_cyc, 1'b0);
    check("err s_ack", be_s_ack, 1'b0);
    mack = 1'b1;
    tick();
    check("err one cycle", be_s_err, 1'b0);
    check("err late ack", be_s_ack, 1'b0);
    mack = 1'b0;
    tick();

    // Abort with two reads outstanding.
    for (int a = 0; a < 2; a++) begin
      stb = 1'b1; addr = 30'h50 + 30'(a);
      tick();
    end
    stb = 1'b0; cyc = 1'b0;
    tick();
    check("abort m_cyc", be_m_cyc, 1'b0);
    check("abort m_stb", be_m_stb, 1'b0);
    mack = 1'b1;
    tick();
    check("abort late ack", be_s_ack, 1'b0);
    mack = 1'b0; cyc = 1'b1;
    tick();

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      cyc    = ($urandom_range(0, 49) != 0);
      stb    = ($urandom_range(0, 9) < 6);
      we     = 1'($urandom);
      addr   = 30'($urandom);
      sdata  = $urandom;
      sel    = 4'($urandom);
      mstall = ($urandom_range(0, 9) < 4);
      mack   = 1'($urandom);
      merr   = ($urandom_range(0, 59) == 0);
      mdata  = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    cyc = 1'b1; stb = 1'b0; mack = 1'b0; merr = 1'b0; mstall = 1'b0;
    tick();
    tick();

    // Reset in the middle of three outstanding reads.
    we = 1'b0;
    for (int a = 0; a < 3; a++) begin
      if (a == 2) mstall = 1'b1;
      stb = 1'b1; addr = 30'h60 + 30'(a);
      tick();
    end
    stb = 1'b0;
    check("pre-reset m_stb", be_m_stb, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid reset m_cyc", be_m_cyc, 1'b0);
    check("mid reset m_stb", be_m_stb, 1'b0);
    check("mid reset s_ack", be_s_ack, 1'b0);
    check("mid reset le m_cyc", le_m_cyc, 1'b0);
    mstall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    tick();
    stb = 1'b1; addr = 30'h5;
    tick();
    stb = 1'b0;
    mack = 1'b1;
    mdata = 128'hAAAA0000_BBBB1111_CCCC2222_DDDD3333;
    tick();
    mack = 1'b0;
    check("post-reset ack", be_s_ack, 1'b1);
    check("post-reset be data", be_s_data, 32'hBBBB1111);
    check("post-reset le data", le_s_data, 32'hCCCC2222);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
